// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, frame constants and parity helper.
// Used by both the transmitter and the receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  localparam int DATA_BITS            = 8;
  localparam int DEFAULT_CLKS_PER_BIT = 434;

  function automatic logic even_parity(input logic [7:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Baud-rate counter: counts 0..CLKS_PER_BIT-1 while enabled, tick on terminal count.
// clr has priority and restarts the bit period from zero.
module uart_baud_cnt #(
  parameter int CLKS_PER_BIT = 434,
  parameter int CNT_W        = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam logic [CNT_W-1:0] TERM = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  logic [CNT_W-1:0] cnt;

  assign tick = en && (cnt == TERM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || tick) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + ONE;
    end else begin
      cnt <= cnt;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter; define UART_TX_PARITY_EN to add an even-parity bit (8E1).
// All outputs are registered; the baud counter runs only while a frame is active.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int CNT_W        = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       trmt,
  input  logic [7:0] tx_data,
  output logic       TX,
  output logic       busy,
  output logic       tx_done
);

  localparam logic [2:0] LAST_IDX = 3'(DATA_BITS - 1);

  tx_state_t  state;
  logic [7:0] shift;
  logic [2:0] idx;
  logic       tick;
  logic       accept;
`ifdef UART_TX_PARITY_EN
  logic       par;
`endif

  assign accept = (state == IDLE) && trmt;

  uart_baud_cnt #(
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .CNT_W       (CNT_W)
  ) u_baud (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (accept),
    .en   (state != IDLE),
    .tick (tick)
  );

  // Frame sequencer; TX is registered so each bit lines up with the baud tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      TX      <= 1'b1;
      busy    <= 1'b0;
      tx_done <= 1'b0;
      shift   <= 8'hFF;
      idx     <= 3'd0;
`ifdef UART_TX_PARITY_EN
      par     <= 1'b0;
`endif
    end else begin
      tx_done <= 1'b0;
      case (state)
        IDLE: begin
          if (trmt) begin
            state <= START;
            busy  <= 1'b1;
            TX    <= 1'b0;
            shift <= tx_data;
            idx   <= 3'd0;
`ifdef UART_TX_PARITY_EN
            par   <= even_parity(tx_data);
`endif
          end
        end
        START: begin
          if (tick) begin
            state <= DATA;
            TX    <= shift[0];
          end
        end
        DATA: begin
          if (tick) begin
            shift <= {1'b1, shift[7:1]};
            if (idx == LAST_IDX) begin
`ifdef UART_TX_PARITY_EN
              state <= PARITY;
              TX    <= par;
`else
              state <= STOP;
              TX    <= 1'b1;
`endif
            end else begin
              idx <= idx + 3'd1;
              TX  <= shift[1];
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (tick) begin
            state <= STOP;
            TX    <= 1'b1;
          end
        end
`endif
        STOP: begin
          if (tick) begin
            state   <= IDLE;
            busy    <= 1'b0;
            tx_done <= 1'b1;
            TX      <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          TX    <= 1'b1;
        end
      endcase
    end
  end

endmodule
